// File: rtl/den_giao_thong.sv
// Two-way traffic-light controller: Moore FSM with a 16-bit per-phase counter,
// sequencing A green/yellow, all-red, B green/yellow, all-red.
module den_giao_thong #(
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] street_a,
    output logic [2:0] street_b
);

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        RED_AB   = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        RED_BA   = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    // Terminal count per phase; a phase of duration D ends when cnt == D-1.
    localparam logic [15:0] G_LAST = 16'(GREEN_CYCLES - 1);
    localparam logic [15:0] Y_LAST = 16'(YELLOW_CYCLES - 1);
    localparam logic [15:0] R_LAST = 16'(ALLRED_CYCLES - 1);

    state_t      state, state_nxt, succ;
    logic [15:0] cnt, cnt_nxt, last;
    logic        legal;

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= A_GREEN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        succ      = A_GREEN;
        last      = '0;
        legal     = 1'b1;
        street_a  = LAMP_R;
        street_b  = LAMP_R;

        case (state)
            A_GREEN: begin
                last     = G_LAST;
                succ     = A_YELLOW;
                street_a = LAMP_G;
            end
            A_YELLOW: begin
                last     = Y_LAST;
                succ     = RED_AB;
                street_a = LAMP_Y;
            end
            RED_AB: begin
                last = R_LAST;
                succ = B_GREEN;
            end
            B_GREEN: begin
                last     = G_LAST;
                succ     = B_YELLOW;
                street_b = LAMP_G;
            end
            B_YELLOW: begin
                last     = Y_LAST;
                succ     = RED_BA;
                street_b = LAMP_Y;
            end
            RED_BA: begin
                last = R_LAST;
                succ = A_GREEN;
            end
            // Unused encodings show all-red and fall back to the start of the cycle.
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            state_nxt = A_GREEN;
            cnt_nxt   = '0;
        end else if (cnt == last) begin
            state_nxt = succ;
            cnt_nxt   = '0;
        end
    end

endmodule

// File: tb/tb_den_giao_thong.sv
// Directed bench for den_giao_thong: table-driven schedule check plus
// safety, mid-phase reset, held reset and minimal-duration sequences.
module tb_den_giao_thong;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] street_a, street_b;
    logic [2:0] min_a, min_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    den_giao_thong dut (
        .clk(clk), .rst_n(rst_n), .street_a(street_a), .street_b(street_b)
    );

    den_giao_thong #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1)) dut_min (
        .clk(clk), .rst_n(rst_n), .street_a(min_a), .street_b(min_b)
    );

    typedef struct {
        logic       rst;
        logic [2:0] a;
        logic [2:0] b;
    } vec_t;

    // Lamp pairs indexed AG, AY, RAB, BG, BY, RBA.
    logic [2:0] exp_a [6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] exp_b [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    int         dur   [6] = '{8, 3, 1, 8, 3, 1};

    int   sched [$];
    vec_t tbl   [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_pair(input string name, input logic [2:0] a, input logic [2:0] b,
                            input int s);
        chk({name, ".a"}, a, exp_a[s]);
        chk({name, ".b"}, b, exp_b[s]);
    endtask

    task automatic chk_safe(input string name, input logic [2:0] a, input logic [2:0] b);
        checks++;
        if ($countones(a) != 1 || $countones(b) != 1 || (a != 3'b100 && b != 3'b100)) begin
            failures++;
            $display("FAIL %s: a=%b b=%b not one-hot or no red street", name, a, b);
        end
    endtask

    // Release reset and check the 8-cycle A green then the move to yellow.
    task automatic green_then_yellow(input string name);
        rst_n = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_pair(name, street_a, street_b, 0);
        end
        tick();
        chk_pair(name, street_a, street_b, 1);
    endtask

    initial begin
        // One period of state indices, one entry per cycle.
        for (int s = 0; s < 6; s++)
            for (int d = 0; d < dur[s]; d++)
                sched.push_back(s);

        // Two reset edges, then edges 1..48 after the last reset edge.
        for (int i = 0; i < 2; i++)
            tbl.push_back('{rst: 1'b1, a: 3'b001, b: 3'b100});
        for (int e = 1; e <= 48; e++)
            tbl.push_back('{rst: 1'b0, a: exp_a[sched[e % 24]], b: exp_b[sched[e % 24]]});

        // Reset + two full periods, table driven.
        for (int i = 0; i < tbl.size(); i++) begin
            rst_n = tbl[i].rst;
            tick();
            chk($sformatf("sched[%0d].a", i), street_a, tbl[i].a);
            chk($sformatf("sched[%0d].b", i), street_b, tbl[i].b);
        end

        // Safety over 500 cycles on both instances.
        for (int i = 0; i < 500; i++) begin
            tick();
            chk_safe("safe_dflt", street_a, street_b);
            chk_safe("safe_min", min_a, min_b);
        end

        // Reset with defaults: 2 edges high, then release.
        rst_n = 1'b1;
        tick();
        tick();
        chk_pair("rst2", street_a, street_b, 0);
        green_then_yellow("rst2_run");

        // Mid-phase reset during B_GREEN at count 4 (edge 16 after reset edge).
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        for (int e = 1; e <= 16; e++) tick();
        chk_pair("mid_pre", street_a, street_b, 3);
        rst_n = 1'b1;
        tick();
        chk_pair("mid_rst", street_a, street_b, 0);
        green_then_yellow("mid_run");

        // Reset held for 30 cycles.
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk_pair("hold", street_a, street_b, 0);
        end
        green_then_yellow("hold_run");

        // Minimal durations: state changes every edge, period 6.
        rst_n = 1'b1;
        tick();
        chk_pair("min_rst", min_a, min_b, 0);
        rst_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk_pair($sformatf("min[%0d]", e), min_a, min_b, e % 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/den_giao_thong.md
# den_giao_thong

Two-way traffic-light controller for a single intersection of street A and street B. A Moore state machine with a per-phase cycle counter sequences each street through green, yellow and red. An all-red clearance interval separates the two streets' right-of-way, so both streets are never non-red at the same time. The block sits at the top of the traffic-light design and drives the lamp outputs directly; it has no inputs other than clock and reset.

## Interface
Parameters (all durations in clock cycles; each must be in 1..65535):
- GREEN_CYCLES, default 8: duration of a green phase.
- YELLOW_CYCLES, default 3: duration of a yellow phase.
- ALLRED_CYCLES, default 1: duration of each all-red clearance phase.

Ports:
- clk  input  1  system clock; all state changes occur on its rising edge.
- rst_n  input  1  one clock; reset is synchronous and active-high (rst_n = 1 resets on the rising edge of clk).
- street_a  output  3  street A lamps, one-hot: bit2 = red, bit1 = yellow, bit0 = green.
- street_b  output  3  street B lamps, same encoding as street_a.

## Operation
- States, in cyclic order:
  - A_GREEN: A = 001, B = 100.
  - A_YELLOW: A = 010, B = 100.
  - RED_AB: A = 100, B = 100.
  - B_GREEN: A = 100, B = 001.
  - B_YELLOW: A = 100, B = 010.
  - RED_BA: A = 100, B = 100.
- After RED_BA, the sequence returns to A_GREEN.
- Phase counter is 16 bits wide. In each state it counts 0 .. D-1, where D is that state's duration parameter.
  - When counter == D-1: advance to the next state and clear the counter to 0.
  - Otherwise: increment the counter and hold the state.
- Each state therefore lasts exactly D cycles. With D = 1, the state lasts a single cycle.
- Full period = 2 × (GREEN_CYCLES + YELLOW_CYCLES + ALLRED_CYCLES) cycles; 24 with the defaults.
- Outputs are a pure decode of the state register (Moore). There is no dependency on the counter.
- Invariants:
  - Each output has exactly one bit set.
  - At least one street is red in every cycle.
  - Green never goes directly to red or to the other street's green.
- Unused or illegal state encodings recover to A_GREEN with the counter at 0 on the next clock edge.
- Reset: on a rising edge with rst_n = 1, state ← A_GREEN and counter ← 0, regardless of current state or count. This includes reset asserted mid-phase.
- While rst_n stays 1, the block holds A_GREEN/counter 0; outputs stay A = 001, B = 100.
- Output values before the first reset edge are unspecified.

## Timing
- Reset value of outputs: street_a = 3'b001, street_b = 3'b100. These are visible after the first clock edge with rst_n = 1.
- Let edge 0 be the last edge with rst_n = 1. A_GREEN then holds for edges 0 .. GREEN_CYCLES-1.
- On edge GREEN_CYCLES, outputs change to A_YELLOW.
- Transitions take effect on the clock edge where counter == D-1. Outputs change in the same edge as the state register, with no extra latency.
- Default schedule, counting edges after the reset edge (outputs valid after each edge):

  | Edges after reset edge | State |
  |---|---|
  | 0–7 | A_GREEN |
  | 8–10 | A_YELLOW |
  | 11 | RED_AB |
  | 12–19 | B_GREEN |
  | 20–22 | B_YELLOW |
  | 23 | RED_BA |
  | 24 | A_GREEN (period repeats) |

- Reset has priority over the counter terminal condition when both occur on the same edge.

## Test plan
- Reset with defaults: hold rst_n = 1 for 2 edges, then release → A = 001 and B = 100 for 8 consecutive cycles, then A = 010.
- Full cycle with defaults: run 48 cycles after reset → the state sequence and durations match the schedule (8, 3, 1, 8, 3, 1) twice with no deviation.
- Safety checker: over 500 cycles → each output is one-hot every cycle, and (A != 100 && B != 100) never occurs.
- Mid-phase reset: assert rst_n = 1 for one edge during B_GREEN at count 4 → the next cycle shows A = 001, B = 100, and the full 8-cycle A green follows.
- Minimal durations: GREEN_CYCLES = YELLOW_CYCLES = ALLRED_CYCLES = 1 → the state changes every cycle, and the period is 6 cycles.
- Reset held: keep rst_n = 1 for 30 cycles → outputs remain A = 001, B = 100 throughout; normal sequencing resumes after release.
